uart_tx_feeder: RTL and testbench
=================================

# uart_tx_feeder

Transmit front-end sitting directly upstream of the UART transmit control path. It accepts bytes from a host write port into a small FIFO, then sequences each byte into the transmitter through the request/acknowledge pairs `load_xmt_datareg`/`load_xmt_datareg_out`, `byte_ready`/`load_xmt_shiftreg` and `t_byte`/`start`. It waits for `clear` (end of frame) before launching the next byte. It also enforces a programmable inter-frame gap and reports FIFO level and overflow.

## Interface
- `word_size`, 8, data width of FIFO entries and `data_bus`
- `fifo_depth`, 4, FIFO entries; power of two, ≥2
- `ptr_bits`, 2, log2(`fifo_depth`)
- `gap_cycles`, 0, idle cycles forced after `clear` before the next load
- `gap_bits`, 4, width of gap counter; `gap_cycles` < 2^`gap_bits`
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_data`  in  `word_size`  host byte
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  FIFO not full; write accepted on an edge with `wr_valid && wr_ready`
- `clr_ovf`  in  1  clears `overflow`
- `level`  out  `ptr_bits`+1  FIFO occupancy, 0..`fifo_depth`
- `overflow`  out  1  sticky; set on `wr_valid && !wr_ready`
- `busy`  out  1  sequencer not in IDLE
- `data_bus`  out  `word_size`  registered byte presented to the transmit datapath
- `load_xmt_datareg`  out  1  request: latch `data_bus`
- `byte_ready`  out  1  request: move data register into shift register
- `t_byte`  out  1  request: start frame
- `load_xmt_datareg_out`  in  1  ack for `load_xmt_datareg`
- `load_xmt_shiftreg`  in  1  ack for `byte_ready`
- `start`  in  1  ack for `t_byte`
- `clear`  in  1  frame complete

## Operation
- FIFO: circular buffer, `ptr_bits` read/write pointers, wrap modulo `fifo_depth`. Push on accepted write. Pop on IDLE→LOAD transition. Push and pop on the same edge leave `level` unchanged.
- Writing while full is rejected even if a pop occurs on the same edge (`wr_ready` reflects pre-edge state). FIFO contents are unchanged and `overflow` is set. `overflow` clears only via `clr_ovf` or `rst`; set wins if both occur on the same edge.
- Sequencer states (outputs decoded from state only):
  - IDLE: no requests. Go to LOAD when `level`≠0 and gap counter = 0; capture FIFO head into `data_bus`; pop.
  - LOAD: `load_xmt_datareg`=1. On `load_xmt_datareg_out`, go to ARM.
  - ARM: `byte_ready`=1. On `load_xmt_shiftreg`, go to START.
  - START: `t_byte`=1. On `start`, go to BUSY.
  - BUSY: no requests. On `clear`, go to IDLE and load gap counter with `gap_cycles`.
- Gap counter decrements in IDLE while nonzero. With `gap_cycles`=0, IDLE lasts exactly 1 cycle between frames.
- Acks arriving in a state that does not expect them are ignored. An unreachable state encoding goes to IDLE.
- Reset: FIFO empty, pointers 0, `level`=0, `overflow`=0, gap counter 0, state IDLE, `data_bus`=0, all requests 0, `busy`=0, `wr_ready`=1.
- Reset mid-frame abandons the in-flight byte and flushes the FIFO. The transmit control block is reset independently.

## Timing
- Each request is held until its ack is sampled high on a rising edge; it deasserts in the following cycle. Minimum 1 cycle per request.
- Byte accepted on edge N into empty FIFO, idle sequencer: `level`=1 after N, LOAD entered at N+1, `load_xmt_datareg` high in the cycle after N+1.
- With acks same-cycle: LOAD, ARM and START each last 1 cycle, so `t_byte` is high in the cycle after N+3.
- `busy` is high from LOAD entry until IDLE re-entry.
- `data_bus` is stable from LOAD entry through the next IDLE→LOAD transition.

## Test plan
- Reset then write 0xA5, acks tied same-cycle → `data_bus`=0xA5. `load_xmt_datareg`, `byte_ready`, `t_byte` each pulse 1 cycle in order, starting 2 cycles after the write edge. `level` returns to 0.
- Write 0x11,0x22,0x33,0x44,0x55 back-to-back with `clear` withheld, depth 4 → 0x11 in flight, 0x22..0x55 queued, `level`=4, `wr_ready`=0. Sixth write sets `overflow`. `clr_ovf` clears it.
- Delay `load_xmt_shiftreg` by 5 cycles → `byte_ready` held 6 cycles, `t_byte` not asserted until after the ack.
- `gap_cycles`=3, two queued bytes → exactly 4 IDLE cycles between `clear` and the second `load_xmt_datareg`.
- Push while full with simultaneous pop → write rejected, `level`=3 afterwards, `overflow`=1.
- Assert `rst` during ARM with 2 bytes queued → next cycle all outputs at reset values. Spurious `start`/`clear` afterwards cause no request.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host write port and transmit-control handshake bundle
interface uart_tx_feeder_if #(
  parameter int word_size = 8,
  parameter int ptr_bits  = 2
);
  logic [word_size-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 clr_ovf;
  logic [ptr_bits:0]    level;
  logic                 overflow;
  logic                 busy;
  logic [word_size-1:0] data_bus;
  logic                 load_xmt_datareg;
  logic                 byte_ready;
  logic                 t_byte;
  logic                 load_xmt_datareg_out;
  logic                 load_xmt_shiftreg;
  logic                 start;
  logic                 clear;

  // host plus transmit control block
  modport master (
    output wr_data, wr_valid, clr_ovf,
    output load_xmt_datareg_out, load_xmt_shiftreg, start, clear,
    input  wr_ready, level, overflow, busy, data_bus,
    input  load_xmt_datareg, byte_ready, t_byte
  );

  // the feeder
  modport slave (
    input  wr_data, wr_valid, clr_ovf,
    input  load_xmt_datareg_out, load_xmt_shiftreg, start, clear,
    output wr_ready, level, overflow, busy, data_bus,
    output load_xmt_datareg, byte_ready, t_byte
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and request/ack sequencer feeding the UART transmitter
module uart_tx_feeder #(
  parameter int word_size  = 8,
  parameter int fifo_depth = 4,
  parameter int ptr_bits   = 2,
  parameter int gap_cycles = 0,
  parameter int gap_bits   = 4
) (
  input logic             clk,
  input logic             rst,
  uart_tx_feeder_if.slave bus
);

  localparam logic [ptr_bits:0]   DepthLv = (ptr_bits + 1)'(fifo_depth);
  localparam logic [gap_bits-1:0] GapLv   = gap_bits'(gap_cycles);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_START = 3'd3,
    S_BUSY  = 3'd4
  } state_e;

  state_e                state_q;
  logic [word_size-1:0]  mem_q [fifo_depth];
  logic [ptr_bits-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_bits-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ptr_bits:0]     count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [gap_bits-1:0]   gap_q;
  logic [word_size-1:0]  data_q;
  logic                  load_q, arm_q, tbyte_q, busy_q;
  logic                  full;
  logic                  push;
  logic                  pop;

  // wr_ready reflects pre-edge occupancy, so a pop on the same edge never frees a slot early
  assign full = (count_q == DepthLv);
  assign push = bus.wr_valid && !full;
  assign pop  = (state_q == S_IDLE) && (count_q != '0) && (gap_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.wr_valid && full) ovf_d = 1'b1;
    else if (bus.clr_ovf)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      arm_q   <= 1'b0;
      tbyte_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - gap_bits'(1);
          end else if (count_q != '0) begin
            state_q <= S_LOAD;
            data_q  <= mem_q[rd_ptr_q];
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.load_xmt_datareg_out) begin
            state_q <= S_ARM;
            load_q  <= 1'b0;
            arm_q   <= 1'b1;
          end
        end
        S_ARM: begin
          if (bus.load_xmt_shiftreg) begin
            state_q <= S_START;
            arm_q   <= 1'b0;
            tbyte_q <= 1'b1;
          end
        end
        S_START: begin
          if (bus.start) begin
            state_q <= S_BUSY;
            tbyte_q <= 1'b0;
          end
        end
        S_BUSY: begin
          if (bus.clear) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            gap_q   <= GapLv;
          end
        end
        default: begin
          state_q <= S_IDLE;
          load_q  <= 1'b0;
          arm_q   <= 1'b0;
          tbyte_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready         = !full;
  assign bus.level            = count_q;
  assign bus.overflow         = ovf_q;
  assign bus.busy             = busy_q;
  assign bus.data_bus         = data_q;
  assign bus.load_xmt_datareg = load_q;
  assign bus.byte_ready       = arm_q;
  assign bus.t_byte           = tbyte_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - two feeder instances (gap 0 and gap 3) against a queue-based reference
module tb_uart_tx_feeder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid, clr_ovf, ack_ld, ack_sh, ack_st, clear;

  always #5 clk = ~clk;

  uart_tx_feeder_if #(.word_size(8), .ptr_bits(2)) if0 ();
  uart_tx_feeder_if #(.word_size(8), .ptr_bits(2)) if1 ();

  assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;
  assign if0.wr_valid = wr_valid; assign if1.wr_valid = wr_valid;
  assign if0.clr_ovf = clr_ovf;  assign if1.clr_ovf = clr_ovf;
  assign if0.load_xmt_datareg_out = ack_ld; assign if1.load_xmt_datareg_out = ack_ld;
  assign if0.load_xmt_shiftreg = ack_sh;    assign if1.load_xmt_shiftreg = ack_sh;
  assign if0.start = ack_st;     assign if1.start = ack_st;
  assign if0.clear = clear;      assign if1.clear = clear;

  uart_tx_feeder #(.word_size(8), .fifo_depth(DEPTH), .ptr_bits(2), .gap_cycles(0), .gap_bits(4))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_feeder #(.word_size(8), .fifo_depth(DEPTH), .ptr_bits(2), .gap_cycles(3), .gap_bits(4))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a byte queue per instance, plus which request (1..3) is outstanding, 4 = awaiting clear
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         stage[2];
  int         gap[2];
  logic [7:0] cur[2];
  logic       ovf[2];

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_step(input int m, input logic r, input logic wv, input logic [7:0] wd,
                            input logic co, input logic a1, input logic a2, input logic a3,
                            input logic cl);
    int sz;
    bit acc;
    if (r) begin
      if (m == 0) q0.delete(); else q1.delete();
      stage[m] = 0; gap[m] = 0; cur[m] = 8'h00; ovf[m] = 1'b0;
      return;
    end
    sz  = qsize(m);
    acc = wv && (sz < DEPTH);
    if (wv && !acc) ovf[m] = 1'b1;
    else if (co)    ovf[m] = 1'b0;
    case (stage[m])
      0: begin
        if (gap[m] > 0) gap[m]--;
        else if (sz > 0) begin
          cur[m]   = (m == 0) ? q0.pop_front() : q1.pop_front();
          stage[m] = 1;
        end
      end
      1: if (a1) stage[m] = 2;
      2: if (a2) stage[m] = 3;
      3: if (a3) stage[m] = 4;
      default: if (cl) begin stage[m] = 0; gap[m] = (m == 0) ? 0 : 3; end
    endcase
    if (acc) begin
      if (m == 0) q0.push_back(wd); else q1.push_back(wd);
    end
  endtask

  task automatic cmp(input int m);
    logic [2:0] lv; logic wr, ov, bs, ld, br, tb; logic [7:0] db;
    string p;
    p = (m == 0) ? "d0" : "d1";
    if (m == 0) begin
      lv = if0.level; wr = if0.wr_ready; ov = if0.overflow; bs = if0.busy;
      db = if0.data_bus; ld = if0.load_xmt_datareg; br = if0.byte_ready; tb = if0.t_byte;
    end else begin
      lv = if1.level; wr = if1.wr_ready; ov = if1.overflow; bs = if1.busy;
      db = if1.data_bus; ld = if1.load_xmt_datareg; br = if1.byte_ready; tb = if1.t_byte;
    end
    chk({p, "_level"},    lv, qsize(m));
    chk({p, "_wr_ready"}, wr, qsize(m) < DEPTH);
    chk({p, "_overflow"}, ov, ovf[m]);
    chk({p, "_busy"},     bs, stage[m] != 0);
    chk({p, "_data_bus"}, db, cur[m]);
    chk({p, "_load"},     ld, stage[m] == 1);
    chk({p, "_byte_rdy"}, br, stage[m] == 2);
    chk({p, "_t_byte"},   tb, stage[m] == 3);
  endtask

  task automatic cyc();
    logic r, wv, co, a1, a2, a3, cl; logic [7:0] wd;
    r = rst; wv = wr_valid; wd = wr_data; co = clr_ovf;
    a1 = ack_ld; a2 = ack_sh; a3 = ack_st; cl = clear;
    @(posedge clk);
    model_step(0, r, wv, wd, co, a1, a2, a3, cl);
    model_step(1, r, wv, wd, co, a1, a2, a3, cl);
    #1;
    cmp(0);
    cmp(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       clr;
    logic [2:0] lvl;
    logic       ld, br, tb, bsy;
    logic [7:0] db;
  } vec_t;

  vec_t       tab[6];
  logic [7:0] burst[5];
  int         n, c0, c1;
  bit         seen1;

  initial begin
    rst = 1'b1; wr_data = 8'h00; wr_valid = 1'b0; clr_ovf = 1'b0;
    ack_ld = 1'b0; ack_sh = 1'b0; ack_st = 1'b0; clear = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_level", if0.level, 0);
    chk("reset_wr_ready", if0.wr_ready, 1);
    chk("reset_data_bus", if0.data_bus, 0);

    // single byte, acks tied high
    tab[0] = '{1'b1, 8'hA5, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tab[1] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tab[2] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tab[3] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
    tab[4] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    tab[5] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    ack_ld = 1'b1; ack_sh = 1'b1; ack_st = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = tab[i].wv; wr_data = tab[i].wd; clear = tab[i].clr;
      cyc();
      chk($sformatf("tab%0d_level", i), if0.level, tab[i].lvl);
      chk($sformatf("tab%0d_load", i), if0.load_xmt_datareg, tab[i].ld);
      chk($sformatf("tab%0d_byte_ready", i), if0.byte_ready, tab[i].br);
      chk($sformatf("tab%0d_t_byte", i), if0.t_byte, tab[i].tb);
      chk($sformatf("tab%0d_busy", i), if0.busy, tab[i].bsy);
      chk($sformatf("tab%0d_data_bus", i), if0.data_bus, tab[i].db);
    end
    clear = 1'b0;

    // back-to-back burst with clear withheld, then overflow and push-while-full-with-pop
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = burst[i]; cyc();
    end
    chk("burst_level", if0.level, 4);
    chk("burst_wr_ready", if0.wr_ready, 0);
    chk("burst_in_flight", if0.data_bus, 8'h11);
    chk("burst_no_ovf", if0.overflow, 0);
    wr_data = 8'h66; cyc();
    chk("sixth_overflow", if0.overflow, 1);
    chk("sixth_level", if0.level, 4);
    wr_valid = 1'b0; clr_ovf = 1'b1; cyc();
    chk("clr_ovf", if0.overflow, 0);
    wr_valid = 1'b1; cyc();
    chk("ovf_set_wins", if0.overflow, 1);
    wr_valid = 1'b0; cyc();
    chk("clr_ovf_again", if0.overflow, 0);
    clr_ovf = 1'b0; clear = 1'b1; cyc();
    clear = 1'b0; wr_valid = 1'b1; wr_data = 8'h77; cyc();
    chk("full_pop_level", if0.level, 3);
    chk("full_pop_ovf", if0.overflow, 1);
    chk("full_pop_head", if0.data_bus, 8'h22);
    chk("full_pop_load", if0.load_xmt_datareg, 1);
    wr_valid = 1'b0; clr_ovf = 1'b1; clear = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    chk("drained_level", if0.level, 0);
    clr_ovf = 1'b0; clear = 1'b0;

    // shift-register ack delayed by 5 cycles
    do_reset();
    ack_ld = 1'b1; ack_sh = 1'b0; ack_st = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h5A; cyc(); wr_valid = 1'b0;
    for (int k = 0; k < 10 && !if0.byte_ready; k++) cyc();
    chk("arm_reached", if0.byte_ready, 1);
    n = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (if0.byte_ready) n++;
      chk("arm_no_t_byte", if0.t_byte, 0);
    end
    ack_sh = 1'b1; cyc();
    chk("arm_held_cycles", n, 6);
    chk("arm_released", if0.byte_ready, 0);
    chk("start_after_ack", if0.t_byte, 1);
    cyc();

    // inter-frame gap: 1 idle cycle for gap 0, 4 for gap 3
    do_reset();
    wr_valid = 1'b1; wr_data = 8'h01; cyc();
    wr_data = 8'h02; cyc(); wr_valid = 1'b0;
    for (int k = 0; k < 10 && !if0.t_byte; k++) cyc();
    chk("gap_first_t_byte", if0.t_byte, 1);
    cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    c0 = 0; c1 = 0; seen1 = 1'b0;
    for (int k = 0; k < 20 && !seen1; k++) begin
      if (!if0.busy) c0++;
      if (!if1.busy) c1++;
      if (if1.load_xmt_datareg) seen1 = 1'b1;
      else cyc();
    end
    chk("gap0_idle_cycles", c0, 1);
    chk("gap3_idle_cycles", c1, 4);
    chk("gap3_second_load", seen1, 1);
    chk("gap3_second_byte", if1.data_bus, 8'h02);

    // reset while in ARM with two bytes queued
    do_reset();
    ack_ld = 1'b1; ack_sh = 1'b0; ack_st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'hC0 + 8'(i); cyc();
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 10 && !if0.byte_ready; k++) cyc();
    chk("rst_arm_reached", if0.byte_ready, 1);
    chk("rst_queued", if0.level, 2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_level", if0.level, 0);
    chk("rst_wr_ready", if0.wr_ready, 1);
    chk("rst_busy", if0.busy, 0);
    chk("rst_byte_ready", if0.byte_ready, 0);
    chk("rst_data_bus", if0.data_bus, 0);
    ack_ld = 1'b1; ack_sh = 1'b1; ack_st = 1'b1; clear = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("spurious_no_req", {if0.load_xmt_datareg, if0.byte_ready, if0.t_byte, if0.busy}, 0);
    end
    clear = 1'b0;

    // randomized traffic, both instances checked against the reference every cycle
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_data  = 8'($urandom);
      clr_ovf  = ($urandom_range(0, 99) < 5);
      ack_ld   = ($urandom_range(0, 99) < 60);
      ack_sh   = ($urandom_range(0, 99) < 60);
      ack_st   = ($urandom_range(0, 99) < 60);
      clear    = ($urandom_range(0, 99) < 20);
      rst      = ($urandom_range(0, 999) < 3);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
